multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
- No parameters.
- REQ-001: clk  input  1  sole clock; state updates on rising edge.
- REQ-002: resetn  input  1  asynchronous, active-low reset.
- REQ-003: opcode  input  6  instruction bits [31:26], valid while the instruction register holds the current instruction.
- REQ-004: funct  input  6  instruction bits [5:0].
- REQ-005: zero  input  1  ALU zero flag from the ALU.
- REQ-006: IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  output  1 each  datapath controls.
- REQ-007: ALUSrcB, PCSrc  output  2 each  mux selects.
- REQ-008: PCEn  output  1  PC load enable.
- REQ-009: ALU_control  output  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- REQ-010: illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- REQ-011: state  output  4  current state, for debug.

Function
- REQ-012: Controller SHALL be a Moore FSM; all outputs except PCEn SHALL be decoded from state only.
- REQ-013: State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- REQ-014: Transitions from FETCH and DECODE SHALL be:
  - FETCH->DECODE.
  - DECODE on opcode: 100011/101011->MEMADR; 000000->EXEC; 000100->BRANCH; 001000->ADDIEX; 000010->JUMP; any other->FETCH.
- REQ-015: Remaining transitions SHALL be:
  - MEMADR: lw->MEMRD, sw->MEMWR.
  - MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
  - Encodings 12-15 ->FETCH.
- REQ-016: Per-state outputs SHALL be as listed; any output not listed SHALL be 0:
  - FETCH: ALUSrcB=01, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcB=11.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXEC: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - ADDIWB: RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- REQ-017: PCEn SHALL equal PCWrite OR (Branch AND zero), combinational in the same cycle as zero.
- REQ-018: ALU_control from ALUOp SHALL be: ALUOp 00->010; 01->110; 10->decoded from funct.
- REQ-019: funct decode SHALL be: 100000->010; 100010->110; 100100->000; 100101->001; 101010->111; any other->010.
- REQ-020: illegal_op SHALL be 1 for exactly the DECODE cycle in which the opcode is unsupported.
- REQ-021: CPI SHALL be: lw 5; sw, R-type and addi 4; beq and j 3; illegal 2.

Reset
- REQ-022: resetn low SHALL immediately force state=FETCH, independent of clk.
- REQ-023: While resetn is low, IRWrite, PCEn, MemWrite, RegWrite and illegal_op SHALL be 0; all other outputs SHALL take their FETCH values (ALUSrcB=01, ALU_control=010).
- REQ-024: The first rising edge after resetn deasserts SHALL perform a normal FETCH.
- REQ-025: Reset asserted mid-instruction SHALL abandon the instruction with no further write strobes.

Configuration
- REQ-026: Macro ADDI_EN SHALL control addi support:
  - Defined: states ADDIEX and ADDIWB exist and opcode 001000 is supported.
  - Undefined: opcode 001000 is illegal (DECODE->FETCH, illegal_op=1), and encodings 9-10 behave as unused (->FETCH, all outputs 0).

Verification
- REQ-027: Reset low mid-MEMRD -> state=0 immediately, RegWrite=0, IRWrite=0 until release.
- REQ-028: lw (opcode 100011) -> states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 only in cycle 5.
- REQ-029: R-type slt (funct 101010) -> ALU_control=111 in EXEC; RegDst=1 and RegWrite=1 in ALUWB.
- REQ-030: beq (opcode 000100) with zero=1 -> PCEn=1 and PCSrc=01 in BRANCH; with zero=0 -> PCEn=0.
- REQ-031: opcode 111111 -> illegal_op pulses once, state returns to 0, no write strobe asserted.
- REQ-032: addi (opcode 001000) with ADDI_EN defined -> states 0,1,9,10 and RegWrite=1 in ADDIWB; with ADDI_EN undefined -> same response as REQ-031.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit (Moore FSM).
//
// Sequences one instruction through fetch, decode and the per-class
// execute/write-back states, driving the datapath mux selects and strobes.
//
// Ports:
//   clk, resetn        clock (rising edge) and asynchronous active-low reset
//   opcode, funct      instruction fields [31:26] and [5:0]
//   zero               ALU zero flag, used for the beq PC enable
//   IorD .. ALUSrcA    single-bit datapath controls
//   ALUSrcB, PCSrc     2-bit mux selects
//   PCEn               PC load enable (PCWrite | Branch & zero)
//   ALU_control        ALU operation (000 and, 001 or, 010 add, 110 sub, 111 slt)
//   illegal_op         high during the DECODE cycle of an unsupported opcode
//   state              current state, for debug
//
// Build option:
//   ADDI_EN            when defined, addi (opcode 001000) is supported through
//                      ADDIEX/ADDIWB; otherwise it decodes as illegal.
//
// state  | meaning
// -------+--------------------------------------------
// FETCH  | read instruction, PC <= PC + 4
// DECODE | read registers, precompute branch target
// MEMADR | lw/sw effective address
// MEMRD  | lw memory read
// MEMWB  | lw register write-back
// MEMWR  | sw memory write
// EXEC   | R-type ALU operation
// ALUWB  | R-type register write-back
// BRANCH | beq compare, conditional PC load
// ADDIEX | addi ALU operation (ADDI_EN only)
// ADDIWB | addi register write-back (ADDI_EN only)
// JUMP   | j, PC load from jump target

module multicycle_controller (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [2:0] ALU_control,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_d;

    logic       iord, ir_write, mem_write, reg_dst, memto_reg, reg_write;
    logic       alu_src_a, pc_write, branch;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic       op_legal;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        op_legal = 1'b1;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef ADDI_EN
            OP_ADDI:                              op_legal = 1'b1;
`endif
            default:                              op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
`ifdef ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        iord      = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_dst   = 1'b0;
        memto_reg = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        pc_write  = 1'b0;
        branch    = 1'b0;
        alu_src_b = 2'b00;
        pc_src    = 2'b00;
        alu_op    = 2'b00;
        case (state_q)
            S_FETCH:  begin alu_src_b = 2'b01; ir_write = 1'b1; pc_write = 1'b1; end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            S_MEMRD:  iord = 1'b1;
            S_MEMWB:  begin memto_reg = 1'b1; reg_write = 1'b1; end
            S_MEMWR:  begin iord = 1'b1; mem_write = 1'b1; end
            S_EXEC:   begin alu_src_a = 1'b1; alu_op = 2'b10; end
            S_ALUWB:  begin reg_dst = 1'b1; reg_write = 1'b1; end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
`ifdef ADDI_EN
            S_ADDIEX: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            S_ADDIWB: reg_write = 1'b1;
`endif
            S_JUMP:   begin pc_src = 2'b10; pc_write = 1'b1; end
            default:  ;
        endcase
    end

    always_comb begin
        ALU_control = 3'b010;
        case (alu_op)
            2'b01: ALU_control = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: ALU_control = 3'b110;
                    6'b100100: ALU_control = 3'b000;
                    6'b100101: ALU_control = 3'b001;
                    6'b101010: ALU_control = 3'b111;
                    default:   ALU_control = 3'b010;
                endcase
            end
            default: ALU_control = 3'b010;
        endcase
    end

    // State already reads FETCH during reset; the strobes FETCH would assert
    // are additionally masked so nothing is written while reset is held.
    assign IorD       = iord;
    assign IRWrite    = ir_write & resetn;
    assign MemWrite   = mem_write & resetn;
    assign RegDst     = reg_dst;
    assign MemtoReg   = memto_reg;
    assign RegWrite   = reg_write & resetn;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign PCSrc      = pc_src;
    assign PCEn       = resetn & (pc_write | (branch & zero));
    assign illegal_op = resetn & (state_q == S_DECODE) & ~op_legal;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       resetn;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic       PCEn;
    logic [2:0] ALU_control;
    logic       illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int pos    = 0;    // cycle index within the current instruction
    bit cmp_en = 1'b0;

    multicycle_controller dut (
        .clk(clk), .resetn(resetn), .opcode(opcode), .funct(funct), .zero(zero),
        .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn), .ALU_control(ALU_control),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    logic [19:0] dut_vec;
    assign dut_vec = {IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                      ALUSrcB, PCSrc, PCEn, ALU_control, illegal_op, state};

    localparam logic [5:0] LEGAL_OPS [6] = '{6'b100011, 6'b101011, 6'b000000,
                                            6'b000100, 6'b000010, 6'b001000};
    localparam logic [5:0] LEGAL_FN [5] = '{6'b100000, 6'b100010, 6'b100100,
                                           6'b100101, 6'b101010};

    // Instruction class: 0 illegal, 1 lw, 2 sw, 3 R-type, 4 beq, 5 j, 6 addi
    function automatic int iclass(input logic [5:0] op);
        case (op)
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000000: return 3;
            6'b000100: return 4;
            6'b000010: return 5;
`ifdef ADDI_EN
            6'b001000: return 6;
`endif
            default:   return 0;
        endcase
    endfunction

    function automatic int cpi(input logic [5:0] op);
        case (iclass(op))
            1:       return 5;
            2, 3, 6: return 4;
            4, 5:    return 3;
            default: return 2;
        endcase
    endfunction

    // State visited at cycle p of an instruction with this opcode
    function automatic int path(input logic [5:0] op, input int p);
        if (p == 0) return 0;
        if (p == 1) return 1;
        case (iclass(op))
            1: return (p == 2) ? 2 : (p == 3) ? 3 : 4;
            2: return (p == 2) ? 2 : 5;
            3: return (p == 2) ? 6 : 7;
            4: return 8;
            5: return 11;
            6: return (p == 2) ? 9 : 10;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] funct_op(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'd2;
            6'b100010: return 3'd6;
            6'b100100: return 3'd0;
            6'b100101: return 3'd1;
            6'b101010: return 3'd7;
            default:   return 3'd2;
        endcase
    endfunction

    function automatic logic [19:0] model_out(input logic [5:0] op, input logic [5:0] fn,
                                              input logic z, input logic rst_low, input int p);
        int st;
        logic iord, irw, mw, rd, m2r, rw, asa, pcw, br, pcen, ill;
        logic [1:0] asb, pcs, aop;
        logic [2:0] alu;
        st = rst_low ? 0 : path(op, p);
        {iord, irw, mw, rd, m2r, rw, asa, pcw, br} = '0;
        asb = 2'd0; pcs = 2'd0; aop = 2'd0;
        case (st)
            0:  begin asb = 2'd1; irw = 1; pcw = 1; end
            1:  asb = 2'd3;
            2:  begin asa = 1; asb = 2'd2; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin asa = 1; aop = 2'd2; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'd1; pcs = 2'd1; br = 1; end
            9:  begin asa = 1; asb = 2'd2; end
            10: rw = 1;
            11: begin pcs = 2'd2; pcw = 1; end
            default: ;
        endcase
        alu  = (aop == 2'd1) ? 3'd6 : (aop == 2'd2) ? funct_op(fn) : 3'd2;
        pcen = pcw | (br & z);
        ill  = (st == 1) && (iclass(op) == 0);
        if (rst_low) begin
            irw = 0; mw = 0; rw = 0; pcen = 0; ill = 0;
        end
        return {iord, irw, mw, rd, m2r, rw, asa, asb, pcs, pcen, alu, ill, st[3:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn)                   pos <= 0;
        else if (pos + 1 >= cpi(opcode)) pos <= 0;
        else                           pos <= pos + 1;
    end

    always @(negedge clk) begin
        #2;
        if (cmp_en) chk("cycle", {12'd0, dut_vec}, {12'd0, model_out(opcode, funct, zero, !resetn, pos)});
    end

    task automatic start_instr(input logic [5:0] op, input logic [5:0] fn);
        int n = 0;
        @(negedge clk);
        while (pos != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("fetch_timeout", 32'(n), 32'd0);
        opcode = op;
        funct  = fn;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        opcode = 6'd0;
        funct  = 6'd0;
        zero   = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_alusrcb", 32'(ALUSrcB), 32'd1);
        chk("rst_aluctl", 32'(ALU_control), 32'd2);
        chk("rst_strobes", {27'd0, IRWrite, PCEn, MemWrite, RegWrite, illegal_op}, 32'd0);
        cmp_en = 1'b1;
        @(negedge clk);
        #4 resetn = 1'b1;

        // lw: states 0..4, write-back only in the fifth cycle
        start_instr(6'b100011, 6'd0);
        #1 chk("lw_c1_state", 32'(state), 32'd0);
        for (int k = 1; k < 5; k++) begin
            next_cycle();
            chk("lw_state", 32'(state), 32'(k));
            chk("lw_regwrite", 32'(RegWrite), (k == 4) ? 32'd1 : 32'd0);
            chk("lw_memtoreg", 32'(MemtoReg), (k == 4) ? 32'd1 : 32'd0);
        end

        // slt
        start_instr(6'b000000, 6'b101010);
        next_cycle();
        next_cycle();
        chk("slt_exec_aluctl", 32'(ALU_control), 32'd7);
        next_cycle();
        chk("slt_wb", {29'd0, state == 4'd7, RegDst, RegWrite}, 32'd7);

        // beq, zero flag passes straight through to PCEn
        start_instr(6'b000100, 6'd0);
        next_cycle();
        @(negedge clk);
        zero = 1'b1;
        #1;
        chk("beq_z1_pcen", 32'(PCEn), 32'd1);
        chk("beq_pcsrc", 32'(PCSrc), 32'd1);
        zero = 1'b0;
        #1 chk("beq_z0_pcen", 32'(PCEn), 32'd0);

        // illegal opcode
        start_instr(6'b111111, 6'd0);
        next_cycle();
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        chk("ill_nowrite", {29'd0, IRWrite, MemWrite, RegWrite}, 32'd0);
        next_cycle();
        chk("ill_back", {28'd0, state}, 32'd0);
        chk("ill_end", 32'(illegal_op), 32'd0);

        // addi
        start_instr(6'b001000, 6'd0);
        next_cycle();
`ifdef ADDI_EN
        chk("addi_decode_ill", 32'(illegal_op), 32'd0);
        next_cycle();
        chk("addi_ex", 32'(state), 32'd9);
        next_cycle();
        chk("addi_wb", {27'd0, state, RegWrite}, {27'd0, 4'd10, 1'b1});
`else
        chk("addi_ill", 32'(illegal_op), 32'd1);
        next_cycle();
        chk("addi_back", 32'(state), 32'd0);
`endif

        // reset mid-MEMRD
        start_instr(6'b100011, 6'd0);
        next_cycle();
        next_cycle();
        next_cycle();
        chk("pre_rst_memrd", 32'(state), 32'd3);
        resetn = 1'b0;
        #1;
        chk("rst_async_state", 32'(state), 32'd0);
        chk("rst_async_strobe", {30'd0, RegWrite, IRWrite}, 32'd0);
        next_cycle();
        chk("rst_hold", {26'd0, state, RegWrite, IRWrite}, 32'd0);
        #2 resetn = 1'b1;
        next_cycle();
        chk("rst_first_fetch", 32'(state), 32'd1);

        // randomized instruction stream with occasional resets
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (pos == 0) begin
                opcode = ($urandom_range(1, 0) == 1) ? LEGAL_OPS[$urandom_range(5, 0)]
                                                     : 6'($urandom);
                funct  = ($urandom_range(1, 0) == 1) ? LEGAL_FN[$urandom_range(4, 0)]
                                                     : 6'($urandom);
            end
            zero = 1'($urandom);
            if ($urandom_range(199, 0) == 0) begin
                @(posedge clk);
                #2 resetn = 1'b0;
                #1 chk("rnd_rst_state", {27'd0, state, MemWrite | RegWrite | IRWrite}, 32'd0);
                @(negedge clk);
                @(negedge clk);
                #4 resetn = 1'b1;
            end
        end

        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
